// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared core types for the IF stage and the decoder.
//   ADDR_W       word-address width of the PC and the instruction memory
//   NOP          bubble encoding (addi x0,x0,0)
//   pc_t         word-addressed program counter
//   fetch_pkt_t  one instruction as presented across the IF/ID boundary
package instr_fetch_pkg;

  localparam int unsigned ADDR_W  = 14;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef logic [ADDR_W-1:0] pc_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    pc_t                pc;
    logic               valid;
  } fetch_pkt_t;

  // Reset / idle contents of an IF/ID payload
  localparam fetch_pkt_t BUBBLE_PKT = '{instr: NOP, pc: '0, valid: 1'b0};

  // Word-address increment; wraps modulo 2^ADDR_W with no carry out
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + pc_t'(1);
  endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding buffer for an instruction whose BRAM
// read completed while the IF/ID boundary was stalled.
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       drop the entry (redirect); highest priority
//   capture     load cap_pkt and mark the entry valid
//   drain       entry consumed by the output stage
//   cap_pkt     packet to capture
//   sk_v        entry valid
//   sk_pkt      held packet
module fetch_skid_buf
  import instr_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       capture,
  input  logic       drain,
  input  fetch_pkt_t cap_pkt,
  output logic       sk_v,
  output fetch_pkt_t sk_pkt
);

  // Entry state; payload only moves on capture so it is stable while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sk_v   <= 1'b0;
      sk_pkt <= BUBBLE_PKT;
    end else if (flush) begin
      sk_v   <= 1'b0;
    end else if (capture) begin
      sk_v   <= 1'b1;
      sk_pkt <= cap_pkt;
    end else if (drain) begin
      sk_v   <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage. Keeps the word-addressed PC, drives
// the 1-cycle-latency instruction BRAM, presents one instruction + PC per
// cycle, holds under downstream stall via a one-entry skid buffer and kills
// wrong-path fetches on redirect.
//   clk, rst_n    clock and asynchronous active-low reset
//   stall_i       downstream not accepting; hold the presented instruction
//   jump_i        redirect request from the decoder (overrides stall)
//   target_i      redirect word address
//   imem_en_o     BRAM read enable (combinational)
//   imem_addr_o   BRAM word address (combinational)
//   imem_rdata_i  BRAM data, valid the cycle after an enabled read
//   instr_o       presented instruction (registered)
//   pc_o          word address of instr_o (registered)
//   valid_o       instr_o is a real, on-path instruction (registered)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter pc_t RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               jump_i,
  input  pc_t                target_i,
  output logic               imem_en_o,
  output pc_t                imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output pc_t                pc_o,
  output logic               valid_o
);

  pc_t        fetch_pc;
  logic       req_v;
  pc_t        req_pc;
  fetch_pkt_t out_q;
  fetch_pkt_t out_d;
  fetch_pkt_t rd_pkt;
  logic       sk_v;
  fetch_pkt_t sk_pkt;
  logic       do_stall;
  logic       do_adv;

  // Redirect beats stall; stall beats advance
  assign do_stall = stall_i & ~jump_i;
  assign do_adv   = ~stall_i & ~jump_i;

  // BRAM port: a read is issued every cycle except a plain stall
  assign imem_en_o   = rst_n & (jump_i | ~stall_i);
  assign imem_addr_o = jump_i ? target_i : fetch_pc;

  // Data returning this cycle for the read issued last cycle
  assign rd_pkt = '{instr: imem_rdata_i, pc: req_pc, valid: 1'b1};

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (jump_i),
    .capture (do_stall & req_v),
    .drain   (do_adv & sk_v),
    .cap_pkt (rd_pkt),
    .sk_v    (sk_v),
    .sk_pkt  (sk_pkt)
  );

  // Next presented packet: skid first (older), then fresh BRAM data, else bubble.
  // Bubbles keep the last pc so the decoder never sees a spurious address.
  always_comb begin
    out_d = out_q;
    if (jump_i) begin
      out_d.instr = NOP;
      out_d.valid = 1'b0;
    end else if (!stall_i) begin
      if (sk_v) begin
        out_d = sk_pkt;
      end else if (req_v) begin
        out_d = rd_pkt;
      end else begin
        out_d.instr = NOP;
        out_d.valid = 1'b0;
      end
    end
  end

  // PC, in-flight request tracking and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_v    <= 1'b0;
      req_pc   <= RESET_PC;
      out_q    <= BUBBLE_PKT;
    end else begin
      out_q <= out_d;
      if (jump_i) begin
        req_v    <= 1'b1;
        req_pc   <= target_i;
        fetch_pc <= pc_inc(target_i);
      end else if (stall_i) begin
        // Any in-flight read has been parked in the skid entry
        req_v    <= 1'b0;
      end else begin
        req_v    <= 1'b1;
        req_pc   <= fetch_pc;
        fetch_pc <= pc_inc(fetch_pc);
      end
    end
  end

  assign instr_o = out_q.instr;
  assign pc_o    = out_q.pc;
  assign valid_o = out_q.valid;

  // A stall parks the in-flight read and blocks new issue, so the skid entry
  // and an in-flight read can never both be pending on an advance.
  always_ff @(posedge clk) begin
    if (rst_n && do_adv) begin
      assert (!(sk_v && req_v));
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and randomized checks of instr_fetch against a
// transaction-level model of the presented instruction stream.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        jump_i;
  pc_t         target_i;
  logic        imem_en_o;
  pc_t         imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  pc_t         pc_o;
  logic        valid_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: what is presented, the next on-path address to present, and
  // whether that instruction's read has already been issued.
  logic        m_valid;
  pc_t         m_pc;
  logic [31:0] m_instr;
  pc_t         m_next;
  logic        m_primed;
  logic        e_en;
  pc_t         e_addr;
  logic        s_en;
  pc_t         s_addr;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .jump_i       (jump_i),
    .target_i     (target_i),
    .imem_en_o    (imem_en_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .valid_o      (valid_o)
  );

  function automatic logic [31:0] word_at(input pc_t a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous BRAM, 1-cycle read latency
  always @(posedge clk) begin
    if (imem_en_o) imem_rdata_i <= word_at(imem_addr_o);
  end

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = '0;
    m_instr  = NOP;
    m_next   = '0;
    m_primed = 1'b0;
  endtask

  // Apply one cycle of inputs at the falling edge, snapshot the BRAM port,
  // advance the model across the rising edge, return at the next falling edge.
  task automatic drive(input logic s, input logic j, input pc_t t);
    stall_i  = s;
    jump_i   = j;
    target_i = t;
    #1;
    e_en   = j | ~s;
    e_addr = j ? t : (m_next + pc_t'(m_primed));
    s_en   = imem_en_o;
    s_addr = imem_addr_o;
    @(posedge clk);
    if (j) begin
      m_valid  = 1'b0;
      m_instr  = NOP;
      m_next   = t;
      m_primed = 1'b1;
    end else if (!s) begin
      if (m_primed) begin
        m_valid = 1'b1;
        m_pc    = m_next;
        m_instr = word_at(m_next);
        m_next  = m_next + 14'd1;
      end else begin
        m_valid  = 1'b0;
        m_instr  = NOP;
        m_primed = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; jump_i = 1'b0; target_i = '0;
    @(negedge clk);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
    n_cmp++; if (instr_o !== NOP)  begin n_fail++; $display("FAIL reset_instr got %h want %h", instr_o, NOP); end
    n_cmp++; if (pc_o !== 14'h0)   begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_o); end
    n_cmp++; if (imem_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", imem_en_o); end
    rst_n = 1'b1;
    model_reset();
  endtask

  // Boot: bubble on edge 1, pc 0,1,2.. from edge 2; stops with pc_o = 5
  task automatic test_boot();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (s_en !== 1'b1 || s_addr !== pc_t'(k)) begin n_fail++; $display("FAIL boot_issue k=%0d got en=%b addr=%h want en=1 addr=%h", k, s_en, s_addr, pc_t'(k)); end
      n_cmp++; if (valid_o !== (k >= 1)) begin n_fail++; $display("FAIL boot_valid k=%0d got %b want %b", k, valid_o, (k >= 1)); end
      if (k >= 1) begin
        n_cmp++; if (pc_o !== pc_t'(k - 1) || instr_o !== word_at(pc_t'(k - 1))) begin n_fail++; $display("FAIL boot_data k=%0d got pc=%h instr=%h want pc=%h", k, pc_o, instr_o, pc_t'(k - 1)); end
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, '0);
      n_cmp++; if (s_en !== 1'b0) begin n_fail++; $display("FAIL stall_en k=%0d got %b want 0", k, s_en); end
      n_cmp++; if (pc_o !== 14'd5 || instr_o !== word_at(14'd5) || valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_hold k=%0d got pc=%h instr=%h v=%b want pc=5", k, pc_o, instr_o, valid_o); end
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (pc_o !== pc_t'(6 + k) || instr_o !== word_at(pc_t'(6 + k)) || valid_o !== 1'b1) begin n_fail++; $display("FAIL stall_release k=%0d got pc=%h v=%b want pc=%h", k, pc_o, valid_o, pc_t'(6 + k)); end
    end
  endtask

  task automatic test_jump();
    drive(1'b0, 1'b0, '0);
    n_cmp++; if (pc_o !== 14'd8) begin n_fail++; $display("FAIL jump_pre got pc=%h want 8", pc_o); end
    drive(1'b0, 1'b1, 14'h0100);
    n_cmp++; if (s_en !== 1'b1 || s_addr !== 14'h0100) begin n_fail++; $display("FAIL jump_issue got en=%b addr=%h want 1/0100", s_en, s_addr); end
    n_cmp++; if (valid_o !== 1'b0 || instr_o !== NOP) begin n_fail++; $display("FAIL jump_bubble got v=%b instr=%h want 0/NOP", valid_o, instr_o); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (pc_o !== pc_t'(14'h0100 + k) || valid_o !== 1'b1 || instr_o !== word_at(pc_t'(14'h0100 + k))) begin n_fail++; $display("FAIL jump_target k=%0d got pc=%h v=%b", k, pc_o, valid_o); end
    end
  endtask

  task automatic test_jump_stall();
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    n_cmp++; if (pc_o !== 14'h0101 || valid_o !== 1'b1) begin n_fail++; $display("FAIL js_hold got pc=%h v=%b want 0101/1", pc_o, valid_o); end
    drive(1'b1, 1'b1, 14'h0020);
    n_cmp++; if (s_en !== 1'b1 || s_addr !== 14'h0020) begin n_fail++; $display("FAIL js_issue got en=%b addr=%h want 1/0020", s_en, s_addr); end
    n_cmp++; if (valid_o !== 1'b0 || instr_o !== NOP) begin n_fail++; $display("FAIL js_bubble got v=%b instr=%h want 0/NOP", valid_o, instr_o); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (pc_o !== pc_t'(14'h0020 + k) || valid_o !== 1'b1 || instr_o !== word_at(pc_t'(14'h0020 + k))) begin n_fail++; $display("FAIL js_target k=%0d got pc=%h v=%b", k, pc_o, valid_o); end
    end
  endtask

  task automatic test_wrap();
    pc_t exp_pc;
    drive(1'b0, 1'b1, 14'h3FFE);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, '0);
      exp_pc = 14'h3FFE + pc_t'(k);
      n_cmp++; if (pc_o !== exp_pc || valid_o !== 1'b1 || instr_o !== word_at(exp_pc)) begin n_fail++; $display("FAIL wrap k=%0d got pc=%h v=%b want pc=%h", k, pc_o, valid_o, exp_pc); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0 || instr_o !== NOP || pc_o !== 14'h0) begin n_fail++; $display("FAIL rstmid_out got v=%b instr=%h pc=%h want 0/NOP/0", valid_o, instr_o, pc_o); end
    n_cmp++; if (imem_en_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_en got %b want 0", imem_en_o); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, '0);
      n_cmp++; if (valid_o !== (k >= 1)) begin n_fail++; $display("FAIL rstmid_valid k=%0d got %b want %b", k, valid_o, (k >= 1)); end
      if (k >= 1) begin
        n_cmp++; if (pc_o !== pc_t'(k - 1) || instr_o !== word_at(pc_t'(k - 1))) begin n_fail++; $display("FAIL rstmid_restart k=%0d got pc=%h want %h", k, pc_o, pc_t'(k - 1)); end
      end
    end
  endtask

  task automatic test_random();
    logic s, j;
    pc_t  t;
    for (int k = 0; k < 400; k++) begin
      s = ($urandom_range(0, 9) < 3);
      j = ($urandom_range(0, 19) == 0);
      t = ($urandom_range(0, 3) == 0) ? (14'h3FFC + pc_t'($urandom_range(0, 3))) : pc_t'($urandom);
      drive(s, j, t);
      n_cmp++; if (s_en !== e_en || (e_en && s_addr !== e_addr)) begin n_fail++; $display("FAIL rand_issue k=%0d got en=%b addr=%h want en=%b addr=%h", k, s_en, s_addr, e_en, e_addr); end
      n_cmp++; if (valid_o !== m_valid || pc_o !== m_pc || instr_o !== m_instr) begin n_fail++; $display("FAIL rand_out k=%0d got v=%b pc=%h instr=%h want v=%b pc=%h instr=%h", k, valid_o, pc_o, instr_o, m_valid, m_pc, m_instr); end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_stall();
    test_jump();
    test_jump_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
